// File: rtl/maj3_bit_sampler.sv
// maj3_bit_sampler: recovers NBITS oversampled serial bits per arm, voting three centre samples.
module majority3 (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic y
);
    assign y = (a & b) | (a & c) | (b & c);
endmodule

module maj3_bit_sampler #(
    parameter int   OVERSAMPLE = 16,
    parameter int   CNT_W      = 4,
    parameter int   NBITS      = 8,
    parameter logic IDLE_LVL   = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic arm,
    input  logic rx_in,
    output logic bit_out,
    output logic bit_valid,
    output logic noisy,
    output logic busy,
    output logic done
);
    localparam int MID = OVERSAMPLE / 2;
    typedef enum logic [1:0] {IDLE, HUNT, RUN} state_t;
    state_t state_q, state_d;
    logic sync1_q, rx_s_q, prev_q;
    logic [CNT_W-1:0] tick_q;
    logic [7:0] bit_cnt_q;
    logic s0_q, s1_q, bit_out_q, noisy_q, bit_valid_q, done_q;
    logic edge_w, cap2_w, last_w, vote_w;
    assign edge_w = en & (rx_s_q != prev_q);
    assign cap2_w = en & (state_q == RUN) & (tick_q == CNT_W'(MID + 1));
    assign last_w = bit_cnt_q == 8'(NBITS - 1);
    majority3 u_vote (.a(s0_q), .b(s1_q), .c(rx_s_q), .y(vote_w));
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sync1_q     <= IDLE_LVL;
            rx_s_q      <= IDLE_LVL;
            prev_q      <= IDLE_LVL;
            tick_q      <= '0;
            bit_cnt_q   <= '0;
            s0_q        <= 1'b0;
            s1_q        <= 1'b0;
            bit_out_q   <= 1'b0;
            noisy_q     <= 1'b0;
            bit_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= rx_in;
            rx_s_q      <= sync1_q;
            bit_valid_q <= cap2_w;
            done_q      <= cap2_w & last_w;
            if (en)
                prev_q <= rx_s_q;
            if (state_q == HUNT && edge_w) begin
                tick_q    <= CNT_W'(1);
                bit_cnt_q <= '0;
            end else if (state_q == RUN && en) begin
                tick_q <= (tick_q == CNT_W'(OVERSAMPLE - 1)) ? '0 : tick_q + 1'b1;
                if (tick_q == CNT_W'(MID - 1))
                    s0_q <= rx_s_q;
                if (tick_q == CNT_W'(MID))
                    s1_q <= rx_s_q;
                if (cap2_w) begin
                    bit_out_q <= vote_w;
                    noisy_q   <= !(s0_q == s1_q && s1_q == rx_s_q);
                    bit_cnt_q <= bit_cnt_q + 1'b1;
                end
            end
        end
    end
    // arm is honoured on any cycle; every other transition waits for an en tick
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = arm ? HUNT : IDLE;
            HUNT:    state_d = edge_w ? RUN : HUNT;
            RUN:     state_d = (cap2_w && last_w) ? IDLE : RUN;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        busy      = state_q != IDLE;
        bit_out   = bit_out_q;
        noisy     = noisy_q;
        bit_valid = bit_valid_q;
        done      = done_q;
    end
endmodule
